// File: rtl/inst_buffer_pkg.sv
// Shared GPGPU sizing and the fill slot selection used by every warp buffer.
// Pure declarations: no latency and no flow control.
package inst_buffer_pkg;

    localparam int GPU_NUM_WARP     = 4;
    localparam int GPU_NUM_WARP_LOG = 2;
    localparam int GPU_INST_WIDTH   = 32;
    localparam int GPU_PC_WIDTH     = 32;

    typedef enum logic [1:0] {
        SLOT_ENTRY0 = 2'd0,
        SLOT_ENTRY1 = 2'd1,
        SLOT_NONE   = 2'd2
    } fillSlot_e;

    // Entry 0 is preferred; both occupied means the fill has nowhere to go.
    function automatic fillSlot_e pickSlot(input logic valid0, input logic valid1);
        fillSlot_e slot;
        slot = SLOT_NONE;
        if (!valid1) slot = SLOT_ENTRY1;
        if (!valid0) slot = SLOT_ENTRY0;
        return slot;
    endfunction

endpackage

// File: rtl/inst_buffer_warp.sv
// Two-entry instruction store for one warp; fill/issue/flush take effect at the next edge.
// No backpressure: a fill into a full warp is dropped and reported on fillDrop.
module inst_buffer_warp
    import inst_buffer_pkg::*;
#(
    parameter int INST_WIDTH = GPU_INST_WIDTH,
    parameter int PC_WIDTH   = GPU_PC_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fillEn,
    input  logic [INST_WIDTH-1:0]    fillInst,
    input  logic [PC_WIDTH-1:0]      fillPc,
    input  logic                     issueEn,
    input  logic                     issueEntry,
    input  logic                     flushEn,
    output logic [1:0]               entryValid,
    output logic [1:0][INST_WIDTH-1:0] entryInst,
    output logic [1:0][PC_WIDTH-1:0] entryPc,
    output logic                     fillDrop
);

    fillSlot_e slot;

    // Slot choice looks at occupancy before this cycle's issue, so a slot
    // freed by an issue only becomes fillable on the following cycle.
    assign slot     = pickSlot(entryValid[0], entryValid[1]);
    assign fillDrop = fillEn && (slot == SLOT_NONE);

    always_ff @(posedge clk) begin
        if (reset || flushEn) begin
            entryValid <= '0;
        end else begin
            if (issueEn) entryValid[issueEntry] <= 1'b0;
            if (fillEn && (slot == SLOT_ENTRY0)) entryValid[0] <= 1'b1;
            if (fillEn && (slot == SLOT_ENTRY1)) entryValid[1] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillEn && (slot == SLOT_ENTRY0)) begin
            entryInst[0] <= fillInst;
            entryPc[0]   <= fillPc;
        end
        if (fillEn && (slot == SLOT_ENTRY1)) begin
            entryInst[1] <= fillInst;
            entryPc[1]   <= fillPc;
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Per-warp two-entry instruction buffer feeding the issue arbiter; issue output is registered (1 cycle).
// No backpressure: fills to a full warp are dropped and flagged on the sticky overflow_o.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int NUM_WARP     = GPU_NUM_WARP,
    parameter int NUM_WARP_LOG = GPU_NUM_WARP_LOG,
    parameter int INST_WIDTH   = GPU_INST_WIDTH,
    parameter int PC_WIDTH     = GPU_PC_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fill_valid_i,
    input  logic [NUM_WARP_LOG-1:0] fill_warp_i,
    input  logic [INST_WIDTH-1:0]   fill_inst_i,
    input  logic [PC_WIDTH-1:0]     fill_pc_i,
    input  logic [NUM_WARP-1:0]     depReady0_i,
    input  logic [NUM_WARP-1:0]     depReady1_i,
    input  logic                    issue_valid_i,
    input  logic [NUM_WARP_LOG-1:0] issue_warp_i,
    input  logic                    issue_entry_i,
    input  logic                    flush_i,
    input  logic [NUM_WARP_LOG-1:0] flush_warp_i,
    output logic [NUM_WARP-1:0]     ReadyVector0_o,
    output logic [NUM_WARP-1:0]     ReadyVector1_o,
    output logic [NUM_WARP_LOG-1:0] preWarp_o,
    output logic [NUM_WARP-1:0]     full_o,
    output logic                    issue_valid_o,
    output logic [INST_WIDTH-1:0]   issue_inst_o,
    output logic [PC_WIDTH-1:0]     issue_pc_o,
    output logic [NUM_WARP_LOG-1:0] issue_warp_o,
    output logic                    overflow_o
);

    logic [1:0]                 warpValid [NUM_WARP];
    logic [1:0][INST_WIDTH-1:0] warpInst  [NUM_WARP];
    logic [1:0][PC_WIDTH-1:0]   warpPc    [NUM_WARP];
    logic [NUM_WARP-1:0]        fillDrop;
    logic                       issueTaken;

    // A flush of the issuing warp wins; issuing an empty entry is a no-op.
    assign issueTaken = issue_valid_i
                     && !(flush_i && (flush_warp_i == issue_warp_i))
                     && warpValid[issue_warp_i][issue_entry_i];

    for (genvar w = 0; w < NUM_WARP; w++) begin : g_warp
        logic isFlush;
        logic isFill;
        logic isIssue;

        assign isFlush = flush_i && (flush_warp_i == NUM_WARP_LOG'(w));
        assign isFill  = fill_valid_i && (fill_warp_i == NUM_WARP_LOG'(w)) && !isFlush;
        assign isIssue = issueTaken && (issue_warp_i == NUM_WARP_LOG'(w));

        inst_buffer_warp #(
            .INST_WIDTH (INST_WIDTH),
            .PC_WIDTH   (PC_WIDTH)
        ) u_warp (
            .clk        (clk),
            .reset      (reset),
            .fillEn     (isFill),
            .fillInst   (fill_inst_i),
            .fillPc     (fill_pc_i),
            .issueEn    (isIssue),
            .issueEntry (issue_entry_i),
            .flushEn    (isFlush),
            .entryValid (warpValid[w]),
            .entryInst  (warpInst[w]),
            .entryPc    (warpPc[w]),
            .fillDrop   (fillDrop[w])
        );

        assign ReadyVector0_o[w] = warpValid[w][0] & depReady0_i[w];
        assign ReadyVector1_o[w] = warpValid[w][1] & depReady1_i[w];
        assign full_o[w]         = warpValid[w][0] & warpValid[w][1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_o <= 1'b0;
            issue_inst_o  <= '0;
            issue_pc_o    <= '0;
            issue_warp_o  <= '0;
            preWarp_o     <= '0;
            overflow_o    <= 1'b0;
        end else begin
            issue_valid_o <= issueTaken;
            overflow_o    <= overflow_o | (|fillDrop);
            if (issueTaken) begin
                issue_inst_o <= warpInst[issue_warp_i][issue_entry_i];
                issue_pc_o   <= warpPc[issue_warp_i][issue_entry_i];
                issue_warp_o <= issue_warp_i;
                preWarp_o    <= issue_warp_i;
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomised and directed stimulus against a slot-array reference model; issued
// instructions are checked by a scoreboard monitor decoupled from the driver.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fill_valid_i = 1'b0;
    logic [1:0]  fill_warp_i = '0;
    logic [31:0] fill_inst_i = '0;
    logic [31:0] fill_pc_i = '0;
    logic [3:0]  depReady0_i = '0;
    logic [3:0]  depReady1_i = '0;
    logic        issue_valid_i = 1'b0;
    logic [1:0]  issue_warp_i = '0;
    logic        issue_entry_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  flush_warp_i = '0;
    logic [3:0]  ReadyVector0_o, ReadyVector1_o, full_o;
    logic [1:0]  preWarp_o, issue_warp_o;
    logic        issue_valid_o, overflow_o;
    logic [31:0] issue_inst_o, issue_pc_o;

    always #5 clk = ~clk;

    inst_buffer #(
        .NUM_WARP(4), .NUM_WARP_LOG(2), .INST_WIDTH(32), .PC_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .fill_valid_i(fill_valid_i), .fill_warp_i(fill_warp_i),
        .fill_inst_i(fill_inst_i), .fill_pc_i(fill_pc_i),
        .depReady0_i(depReady0_i), .depReady1_i(depReady1_i),
        .issue_valid_i(issue_valid_i), .issue_warp_i(issue_warp_i),
        .issue_entry_i(issue_entry_i),
        .flush_i(flush_i), .flush_warp_i(flush_warp_i),
        .ReadyVector0_o(ReadyVector0_o), .ReadyVector1_o(ReadyVector1_o),
        .preWarp_o(preWarp_o), .full_o(full_o),
        .issue_valid_o(issue_valid_o), .issue_inst_o(issue_inst_o),
        .issue_pc_o(issue_pc_o), .issue_warp_o(issue_warp_o),
        .overflow_o(overflow_o)
    );

    typedef struct {
        bit          vld;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  warp;
    } issExp_t;

    issExp_t     expQ[$];
    int          nCmp = 0;
    int          nErr = 0;

    // Reference model: plain slot arrays plus the last issued record.
    bit          mV [4][2];
    logic [31:0] mI [4][2];
    logic [31:0] mP [4][2];
    bit          mOv;
    logic [1:0]  mPre;
    issExp_t     mIss;
    bit          armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkState();
        logic [3:0] r0, r1, f;
        for (int w = 0; w < 4; w++) begin
            r0[w] = mV[w][0] & depReady0_i[w];
            r1[w] = mV[w][1] & depReady1_i[w];
            f[w]  = mV[w][0] & mV[w][1];
        end
        chk("ReadyVector0", 32'(ReadyVector0_o), 32'(r0));
        chk("ReadyVector1", 32'(ReadyVector1_o), 32'(r1));
        chk("full", 32'(full_o), 32'(f));
        chk("overflow", 32'(overflow_o), 32'(mOv));
        chk("preWarp", 32'(preWarp_o), 32'(mPre));
    endtask

    task automatic step(input bit rst, input bit fv, input logic [1:0] fw,
                        input logic [31:0] fi, input logic [31:0] fp,
                        input bit iv, input logic [1:0] iw, input bit ie,
                        input bit fl, input logic [1:0] flw);
        int slot;
        @(negedge clk);
        if (armed) checkState();
        armed = 1'b1;
        reset = rst; fill_valid_i = fv; fill_warp_i = fw; fill_inst_i = fi; fill_pc_i = fp;
        issue_valid_i = iv; issue_warp_i = iw; issue_entry_i = ie;
        flush_i = fl; flush_warp_i = flw;
        if (rst) begin
            for (int w = 0; w < 4; w++) begin
                mV[w][0] = 1'b0;
                mV[w][1] = 1'b0;
            end
            mOv = 1'b0;
            mPre = 2'd0;
            mIss = '{1'b0, 32'd0, 32'd0, 2'd0};
        end else begin
            slot = -1;
            if (fv && !(fl && flw == fw)) begin
                if (!mV[fw][0])      slot = 0;
                else if (!mV[fw][1]) slot = 1;
                else                 mOv = 1'b1;
            end
            mIss.vld = 1'b0;
            if (iv && !(fl && flw == iw) && mV[iw][ie]) begin
                mIss = '{1'b1, mI[iw][ie], mP[iw][ie], iw};
                mV[iw][ie] = 1'b0;
                mPre = iw;
            end
            if (slot >= 0) begin
                mV[fw][slot] = 1'b1;
                mI[fw][slot] = fi;
                mP[fw][slot] = fp;
            end
            if (fl) begin
                mV[flw][0] = 1'b0;
                mV[flw][1] = 1'b0;
            end
        end
        expQ.push_back(mIss);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic fill(input logic [1:0] w, input logic [31:0] inst, input logic [31:0] pc);
        step(1'b0, 1'b1, w, inst, pc, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endtask

    // Scoreboard monitor: one expected record per driven cycle, checked after its edge.
    initial begin : monitor
        issExp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("issue_valid", 32'(issue_valid_o), 32'(e.vld));
                chk("issue_inst", issue_inst_o, e.inst);
                chk("issue_pc", issue_pc_o, e.pc);
                chk("issue_warp", 32'(issue_warp_o), 32'(e.warp));
            end
        end
    end

    initial begin : driver
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd1, 32'h5, 32'h5, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        idle();
        chk("reset issue_valid", 32'(issue_valid_o), 32'd0);
        chk("reset full", 32'(full_o), 32'd0);

        // Single fill lights only its own ready bit.
        depReady0_i = 4'b0100;
        fill(2'd2, 32'hA0, 32'h100);
        idle();
        chk("fill ready0", 32'(ReadyVector0_o), 32'h4);
        chk("fill full", 32'(full_o), 32'd0);

        // Third fill to a full warp is dropped and flags overflow.
        fill(2'd1, 32'h11, 32'h200);
        fill(2'd1, 32'h12, 32'h204);
        fill(2'd1, 32'h13, 32'h208);
        idle();
        chk("overfill full1", 32'(full_o[1]), 32'd1);
        chk("overfill flag", 32'(overflow_o), 32'd1);

        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0);
        idle();
        chk("issue1 valid", 32'(issue_valid_o), 32'd1);
        chk("issue1 inst", issue_inst_o, 32'h12);
        chk("issue1 warp", 32'(issue_warp_o), 32'd1);
        chk("issue1 preWarp", 32'(preWarp_o), 32'd1);
        depReady1_i = 4'hF;
        #1;
        chk("issue1 freed", 32'(ReadyVector1_o[1]), 32'd0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        idle();
        chk("issue0 inst kept", issue_inst_o, 32'h11);

        // Issue frees entry 0 but a same-cycle fill still sees the warp full.
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        fill(2'd3, 32'h31, 32'h300);
        fill(2'd3, 32'h32, 32'h304);
        step(1'b0, 1'b1, 2'd3, 32'h33, 32'h308, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
        idle();
        chk("issue+fill overflow", 32'(overflow_o), 32'd1);
        chk("issue+fill full3", 32'(full_o[3]), 32'd0);
        depReady0_i = 4'hF;
        #1;
        chk("issue+fill entry0", 32'(ReadyVector0_o[3]), 32'd0);
        chk("issue+fill entry1", 32'(ReadyVector1_o[3]), 32'd1);

        // Flush beats fill and issue to the same warp.
        fill(2'd0, 32'h01, 32'h400);
        fill(2'd0, 32'h02, 32'h404);
        step(1'b0, 1'b1, 2'd0, 32'h03, 32'h408, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0);
        idle();
        chk("flush issue_valid", 32'(issue_valid_o), 32'd0);
        chk("flush full0", 32'(full_o[0]), 32'd0);
        chk("flush ready0", 32'(ReadyVector0_o[0]), 32'd0);
        chk("flush overflow kept", 32'(overflow_o), 32'd1);

        // Reset overrides an in-flight issue.
        fill(2'd2, 32'h22, 32'h500);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
        idle();
        chk("rst issue_valid", 32'(issue_valid_o), 32'd0);
        chk("rst ready0", 32'(ReadyVector0_o), 32'd0);
        chk("rst ready1", 32'(ReadyVector1_o), 32'd0);
        chk("rst preWarp", 32'(preWarp_o), 32'd0);

        for (int c = 0; c < 500; c++) begin
            depReady0_i = 4'($urandom);
            depReady1_i = 4'($urandom);
            step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 9) < 6), 2'($urandom),
                 $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom),
                 1'($urandom), 1'($urandom_range(0, 9) == 0), 2'($urandom));
        end
        idle();
        @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
